// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle MULT/DIV into HI/LO, plus MTHI/MTLO/MFHI/MFLO.
// Optional feature macro MDU_MADD_EN enables MADD/MADDU (accumulate into {HI,LO}).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif
    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d, cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic        is_mul, is_div, is_madd, launch;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    always_comb begin
        is_mul  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_div  = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_madd = (mdu_op == OP_MADD) || (mdu_op == OP_MADDU);
`else
        is_madd = 1'b0;
`endif
        launch  = start && !busy_q && (is_mul || is_div || is_madd);
    end

    // Datapath works only on the latched operands so inputs may change freely while busy.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_neg  = (op_q == OP_DIV) && a_q[31];
        b_neg  = (op_q == OP_DIV) && b_q[31];
        a_mag  = a_neg ? -a_q : a_q;
        b_mag  = b_neg ? -b_q : b_q;
        // Magnitude division makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
        q_mag  = (b_mag != 32'd0) ? a_mag / b_mag : 32'd0;
        r_mag  = (b_mag != 32'd0) ? a_mag % b_mag : 32'd0;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                cnt_d  = 4'd0;
                case (op_q)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end
`ifdef MDU_MADD_EN
                    OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                    OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
                    default: ;
                endcase
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (launch) begin
            busy_d = 1'b1;
            cnt_d  = is_div ? DIV_N : MULT_N;
            a_d    = A;
            b_d    = B;
            op_d   = mdu_op;
        end else if (mdu_op == OP_MTHI) begin
            hi_d = A;
        end else if (mdu_op == OP_MTLO) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            op_q   <= 4'd0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        case (mdu_op)
            OP_MFHI: mdu_out = hi_q;
            OP_MFLO: mdu_out = lo_q;
            default: mdu_out = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu with default latencies (5 mult, 10 div).
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] mdu_out, hi, lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .A(A), .B(B), .busy(busy), .mdu_out(mdu_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op, then count busy cycles (bounded) until busy drops.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start = 1'b1; mdu_op = op; A = a; B = b;
        tick();
        start = 1'b0; mdu_op = 4'd0;
        cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            tick();
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        mdu_op = op; A = a;
        tick();
        mdu_op = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b0;
        mdu_op = 4'd5; #1;
        total_cnt++;
        if ({busy, hi, lo, mdu_out} !== 97'd0)
            $display("FAIL reset_state busy=%0b hi=%h lo=%h out=%h want all 0", busy, hi, lo, mdu_out);
        else pass_cnt++;
        mdu_op = 4'd0;
    endtask

    task automatic test_mult();
        int c;
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, c);
        total_cnt++;
        if (c !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA)
            $display("FAIL mult cyc=%0d hi=%h lo=%h want 5 ffffffff fffffffa", c, hi, lo);
        else pass_cnt++;
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, c);
        total_cnt++;
        if (c !== 5 || hi !== 32'h2 || lo !== 32'hFFFFFFFA)
            $display("FAIL multu cyc=%0d hi=%h lo=%h want 5 00000002 fffffffa", c, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int c;
        run_op(4'd3, 32'd7, 32'hFFFFFFFE, c);
        total_cnt++;
        if (c !== 10 || hi !== 32'd1 || lo !== 32'hFFFFFFFD)
            $display("FAIL div_pos_neg cyc=%0d hi=%h lo=%h want 10 00000001 fffffffd", c, hi, lo);
        else pass_cnt++;
        run_op(4'd4, 32'd100, 32'd7, c);
        total_cnt++;
        if (hi !== 32'd2 || lo !== 32'd14)
            $display("FAIL divu hi=%h lo=%h want 00000002 0000000e", hi, lo);
        else pass_cnt++;
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, c);
        total_cnt++;
        if (hi !== 32'd0 || lo !== 32'h80000000)
            $display("FAIL div_ovf hi=%h lo=%h want 00000000 80000000", hi, lo);
        else pass_cnt++;
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, c);
        total_cnt++;
        if (c !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
            $display("FAIL div_neg cyc=%0d hi=%h lo=%h want 10 ffffffff fffffffd", c, hi, lo);
        else pass_cnt++;
        run_op(4'd4, 32'd7, 32'd0, c);
        total_cnt++;
        if (c !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
            $display("FAIL div_zero cyc=%0d hi=%h lo=%h want 10 ffffffff fffffffd", c, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_mt_mf();
        int c;
        mt(4'd7, 32'h12345678);
        mdu_op = 4'd5; #1;
        total_cnt++;
        if (mdu_out !== 32'h12345678)
            $display("FAIL mthi_mfhi out=%h want 12345678", mdu_out);
        else pass_cnt++;
        mt(4'd8, 32'hCAFEBABE);
        mdu_op = 4'd6; #1;
        total_cnt++;
        if (mdu_out !== 32'hCAFEBABE)
            $display("FAIL mtlo_mflo out=%h want cafebabe", mdu_out);
        else pass_cnt++;
        mdu_op = 4'd0; #1;
        total_cnt++;
        if (mdu_out !== 32'd0)
            $display("FAIL out_none out=%h want 00000000", mdu_out);
        else pass_cnt++;
        // MTLO while a divide-by-zero is in flight must not touch LO
        start = 1'b1; mdu_op = 4'd4; A = 32'd1; B = 32'd0;
        tick();
        start = 1'b0;
        mt(4'd8, 32'hDEADBEEF);
        total_cnt++;
        if (lo !== 32'hCAFEBABE)
            $display("FAIL mtlo_busy_mid lo=%h want cafebabe", lo);
        else pass_cnt++;
        c = 0;
        while (busy && c < 20) begin c++; tick(); end
        total_cnt++;
        if (busy !== 1'b0 || lo !== 32'hCAFEBABE || hi !== 32'h12345678)
            $display("FAIL mtlo_busy_end busy=%0b hi=%h lo=%h want 0 12345678 cafebabe", busy, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_no_launch();
        start = 1'b1; mdu_op = 4'd5; A = 32'd9; B = 32'd9;
        tick();
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL nolaunch_mfhi busy=%0b want 0", busy);
        else pass_cnt++;
        mdu_op = 4'd15;
        tick();
        start = 1'b0; mdu_op = 4'd0;
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEBABE)
            $display("FAIL nolaunch_bad busy=%0b hi=%h lo=%h want 0 12345678 cafebabe", busy, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c;
        start = 1'b1; mdu_op = 4'd1; A = 32'hFFFFFFFE; B = 32'd3;
        tick();
        start = 1'b0; mdu_op = 4'd0;
        c = 0;
        while (busy && c < 20) begin
            c++;
            if (c == 2) begin start = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'd7; end
            else begin start = 1'b0; mdu_op = 4'd0; A = 32'd55; B = 32'd66; end
            tick();
        end
        start = 1'b0; mdu_op = 4'd0;
        total_cnt++;
        if (c !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA)
            $display("FAIL start_while_busy cyc=%0d hi=%h lo=%h want 5 ffffffff fffffffa", c, hi, lo);
        else pass_cnt++;
        // immediate relaunch the cycle busy drops
        run_op(4'd2, 32'h10000, 32'h10000, c);
        total_cnt++;
        if (c !== 5 || hi !== 32'd1 || lo !== 32'd0)
            $display("FAIL back_to_back cyc=%0d hi=%h lo=%h want 5 00000001 00000000", c, hi, lo);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        mt(4'd7, 32'hAAAA5555);
        mt(4'd8, 32'h5555AAAA);
        start = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0; mdu_op = 4'd0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_mid busy=%0b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        else pass_cnt++;
        repeat (10) tick();
        mdu_op = 4'd5; #1;
        total_cnt++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mdu_out !== 32'd0)
            $display("FAIL reset_no_commit busy=%0b hi=%h lo=%h out=%h want all 0", busy, hi, lo, mdu_out);
        else pass_cnt++;
        mdu_op = 4'd0;
    endtask

    task automatic test_madd();
        int c;
        mt(4'd7, 32'd0);
        mt(4'd8, 32'hFFFFFFFF);
        run_op(4'd10, 32'd1, 32'd1, c);
`ifdef MDU_MADD_EN
        total_cnt++;
        if (c !== 5 || hi !== 32'd1 || lo !== 32'd0)
            $display("FAIL maddu cyc=%0d hi=%h lo=%h want 5 00000001 00000000", c, hi, lo);
        else pass_cnt++;
        run_op(4'd9, 32'hFFFFFFFF, 32'd1, c);
        total_cnt++;
        if (c !== 5 || hi !== 32'd0 || lo !== 32'hFFFFFFFF)
            $display("FAIL madd cyc=%0d hi=%h lo=%h want 5 00000000 ffffffff", c, hi, lo);
        else pass_cnt++;
`else
        total_cnt++;
        if (c !== 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF)
            $display("FAIL maddu_off cyc=%0d hi=%h lo=%h want 0 00000000 ffffffff", c, hi, lo);
        else pass_cnt++;
        run_op(4'd9, 32'd5, 32'd5, c);
        total_cnt++;
        if (c !== 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF)
            $display("FAIL madd_off cyc=%0d hi=%h lo=%h want 0 00000000 ffffffff", c, hi, lo);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_no_launch();
        test_back_to_back();
        test_reset_mid();
        test_madd();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (and madd/maddu when enabled).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 start  input  1  EX-stage request to launch mult/div-class op; qualified by mdu_op.
REQ-006 mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU; others are NONE.
REQ-007 A  input  32  rs operand (forwarded value).
REQ-008 B  input  32  rt operand (forwarded value).
REQ-009 busy  output  1  high while an op is in flight; hazard unit stalls any MDU instruction in EX while busy|start.
REQ-010 mdu_out  output  32  MFHI -> HI, MFLO -> LO, otherwise 0; registered into EX/MEM as the MDU result.
REQ-011 hi  output  32  committed HI register (debug/observe).
REQ-012 lo  output  32  committed LO register (debug/observe).

Function
REQ-013 mdu_out SHALL be combinational from mdu_op and committed HI/LO; no in-flight result is visible.
REQ-014 Launch: start=1 with op in {1,2,3,4} (plus {9,10} per REQ-029) and busy=0 at edge k latches A, B, op into internal registers.
REQ-015 busy SHALL be 1 during cycles k+1 .. k+N (N=MULT_CYCLES or DIV_CYCLES), then 0 at k+N+1.
REQ-016 HI/LO SHALL update at the edge ending cycle k+N, coincident with busy falling.
REQ-017 Internal down-counter, 4 bits, loaded with N on launch, decremented while busy; result commits when counter reaches 1.
REQ-018 start while busy=1 SHALL be ignored (no relaunch, no operand capture).
REQ-019 start=1 with non-launch op (0, 5-8, unsupported) SHALL NOT launch.
REQ-020 MTHI/MTLO (mdu_op 7/8, start irrelevant) SHALL write A into HI/LO at next edge only when busy=0; ignored while busy.
REQ-021 MULT: {HI,LO} = signed A * signed B (64-bit); MULTU: unsigned product.
REQ-022 DIV: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-023 Divide by zero (B=0 at launch): full busy period runs; HI and LO unchanged at commit.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000; no trap.
REQ-025 Operands used for computation SHALL be the latched copies; A/B changing during busy has no effect.
REQ-026 Parameters SHALL satisfy 1 <= MULT_CYCLES, DIV_CYCLES <= 15.

Reset
REQ-027 reset=1 at an edge SHALL clear HI=0, LO=0, busy=0, counter=0, latched operands/op=0; takes priority over start and MTHI/MTLO.
REQ-028 Reset mid-operation SHALL abandon the op; no commit occurs afterwards; mdu_out=0 for MFHI/MFLO after reset.

Configuration
REQ-029 Macro MDU_MADD_EN: when defined, ops 9/10 launch with MULT_CYCLES latency and commit {HI,LO} += signed (9) / unsigned (10) A*B, mod 2^64, using {HI,LO} at commit.
REQ-030 Without MDU_MADD_EN, ops 9/10 SHALL be treated as NONE (no launch, busy stays 0, HI/LO unchanged).

Verification
REQ-031 MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI/LO unchanged after 10 cycles.
REQ-033 MTHI A=0x12345678 then MFHI -> mdu_out=0x12345678 next cycle; MTLO issued while busy -> LO unchanged.
REQ-034 Launch MULT, reassert start with DIV in cycle k+2 and change A/B -> ignored; commit reflects original MULT operands at k+5.
REQ-035 Launch DIV, reset=1 at cycle k+4 -> busy=0, HI=LO=0 from k+5; no commit at k+10.
REQ-036 With MDU_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0; without macro -> busy never rises, HI=0, LO=0xFFFFFFFF.
